// File: rtl/i2s_pkg.sv
// Shared constants and sample type for the I2S transmit path.
// The synth imports sample_t so FIFO words and the serializer agree on width.
package i2s_pkg;

   localparam int DEF_SCLK_HALF = 8;
   localparam int DEF_SLOT_BITS = 32;
   localparam int DEF_SAMPLE_W  = 24;

   typedef logic [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_tx_if.sv
// FIFO handshake and codec serial port of the I2S transmitter.
// master = transmitter side, slave = FIFO/codec side.
interface i2s_tx_if import i2s_pkg::*; #(
   parameter int SAMPLE_W = DEF_SAMPLE_W
) ();

   logic                FIFO_EMPTY;
   logic [SAMPLE_W-1:0] FIFO_DATA;
   logic                FIFO_READ;
   logic                SCLK;
   logic                LRCLK;
   logic                SDATA;
   logic                UNDERRUN;

   modport master (
      input  FIFO_EMPTY, FIFO_DATA,
      output FIFO_READ, SCLK, LRCLK, SDATA, UNDERRUN
   );

   modport slave (
      output FIFO_EMPTY, FIFO_DATA,
      input  FIFO_READ, SCLK, LRCLK, SDATA, UNDERRUN
   );

endinterface

// File: rtl/i2s_clkgen.sv
// SCLK divider, bit counter and LRCLK decode for the I2S transmitter.
// fall/slot_start/frame_start are single-cycle strobes aligned with the SCLK 1->0 update.
module i2s_clkgen #(
   parameter int SCLK_HALF = 8,
   parameter int SLOT_BITS = 32
) (
   input  logic CLK,
   input  logic RESET,
   output logic sclk,
   output logic lrclk,
   output logic fall,
   output logic slot_start,
   output logic frame_start
);

   localparam int DW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam int BW = $clog2(2 * SLOT_BITS);
   localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_HALF - 1);
   localparam logic [BW-1:0] BC_LAST   = BW'(2 * SLOT_BITS - 1);
   localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT_BITS - 1);

   logic [DW-1:0] div;
   logic [BW-1:0] bc;
   logic          div_tc;

   assign div_tc      = (div == DIV_LAST);
   assign fall        = div_tc && sclk;
   assign frame_start = fall && (bc == BC_LAST);
   assign slot_start  = fall && ((bc == BC_LAST) || (bc == SLOT_LAST));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         div   <= '0;
         sclk  <= 1'b0;
         bc    <= BC_LAST;
         lrclk <= 1'b1;
      end else begin
         if (div_tc) begin
            div  <= '0;
            sclk <= ~sclk;
         end else begin
            div <= div + DW'(1);
         end
         if (fall) begin
            bc <= (bc == BC_LAST) ? '0 : bc + BW'(1);
            // LRCLK is updated together with bc so it is 0 exactly while bc < SLOT_BITS
            if (bc == BC_LAST)
               lrclk <= 1'b0;
            else if (bc == SLOT_LAST)
               lrclk <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter: one FIFO sample per frame, sent on both slots.
// Empty FIFO at frame start repeats the previous sample and pulses UNDERRUN.
module i2s_tx import i2s_pkg::*; #(
   parameter int SCLK_HALF = DEF_SCLK_HALF,
   parameter int SLOT_BITS = DEF_SLOT_BITS,
   parameter int SAMPLE_W  = DEF_SAMPLE_W
) (
   input  logic     CLK,
   input  logic     RESET,
   i2s_tx_if.master bus
);

   logic                sclk;
   logic                lrclk;
   logic                fall;
   logic                slot_start;
   logic                frame_start;
   logic [SAMPLE_W-1:0] hold;
   logic [SAMPLE_W-1:0] sh;
   logic                sdata;
   logic                fifo_read;
   logic                underrun;

   i2s_clkgen #(
      .SCLK_HALF (SCLK_HALF),
      .SLOT_BITS (SLOT_BITS)
   ) u_clkgen (
      .CLK         (CLK),
      .RESET       (RESET),
      .sclk        (sclk),
      .lrclk       (lrclk),
      .fall        (fall),
      .slot_start  (slot_start),
      .frame_start (frame_start)
   );

   // sh is reloaded at each slot start; zero fill after the LSB supplies the pad bits
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hold      <= '0;
         sh        <= '0;
         sdata     <= 1'b0;
         fifo_read <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         fifo_read <= 1'b0;
         underrun  <= 1'b0;
         if (frame_start) begin
            sdata <= 1'b0;
            if (!bus.FIFO_EMPTY) begin
               hold      <= bus.FIFO_DATA;
               sh        <= bus.FIFO_DATA;
               fifo_read <= 1'b1;
            end else begin
               sh       <= hold;
               underrun <= 1'b1;
            end
         end else if (slot_start) begin
            sdata <= 1'b0;
            sh    <= hold;
         end else if (fall) begin
            sdata <= sh[SAMPLE_W-1];
            sh    <= sh << 1;
         end
      end
   end

   assign bus.SCLK      = sclk;
   assign bus.LRCLK     = lrclk;
   assign bus.SDATA     = sdata;
   assign bus.FIFO_READ = fifo_read;
   assign bus.UNDERRUN  = underrun;

endmodule
